// File: rtl/serial_pkg.sv
// Shared types and default field widths for the serial frame receive path.
package serial_pkg;

  localparam int unsigned PORT_BITS_DEF = 2;
  localparam int unsigned LEN_BITS_DEF  = 4;

  typedef enum logic [2:0] {
    IDLE,
    PORT,
    LEN,
    DATA,
    DONE
  } frame_state_t;

endpackage

// File: rtl/field_shifter.sv
// MSB-first header field capture: shifts one bit per enabled cycle and flags the last bit.
module field_shifter #(
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             shift,
  input  logic             bit_in,
  output logic [WIDTH-1:0] value,
  output logic             full
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  logic [CNT_W-1:0] count;

  // full is combinational so the controller can leave the field on the same edge
  assign full = shift && (count == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      value <= '0;
    end else begin
      if (clear) begin
        count <= '0;
      end else if (shift) begin
        count <= count + CNT_W'(1);
      end
      if (shift) begin
        value <= WIDTH'({value, bit_in});
      end
    end
  end

endmodule

// File: rtl/serial_frame_ctrl.sv
// Receive-path sequencer: start bit, port and length fields, payload steering, done handshake.
module serial_frame_ctrl
  import serial_pkg::*;
#(
  parameter int unsigned PORT_BITS = PORT_BITS_DEF,
  parameter int unsigned LEN_BITS  = LEN_BITS_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      serIn,
  input  logic                      transmitted,
  output logic                      serOut,
  output logic                      serOutValid,
  output logic [2**PORT_BITS-1:0]   portValid,
  output logic [PORT_BITS-1:0]      portSel,
  output logic                      busy,
  output logic                      done
);

  localparam int unsigned NUM_PORTS = 2 ** PORT_BITS;

  frame_state_t state, state_next;

  logic                start_c;
  logic                port_shift_c;
  logic                len_shift_c;
  logic                port_full;
  logic                len_full;
  logic [LEN_BITS-1:0] len_value;
  logic [LEN_BITS-1:0] len_now_c;
  logic [LEN_BITS-1:0] remaining;

  assign start_c      = (state == IDLE) && !serIn;
  assign port_shift_c = (state == PORT);
  assign len_shift_c  = (state == LEN);
  // length including the bit being sampled this cycle
  assign len_now_c    = LEN_BITS'({len_value, serIn});
  assign serOut       = serIn;

  field_shifter #(.WIDTH(PORT_BITS)) u_port_field (
    .clk    (clk),
    .rst    (rst),
    .clear  (start_c),
    .shift  (port_shift_c),
    .bit_in (serIn),
    .value  (portSel),
    .full   (port_full)
  );

  field_shifter #(.WIDTH(LEN_BITS)) u_len_field (
    .clk    (clk),
    .rst    (rst),
    .clear  (start_c),
    .shift  (len_shift_c),
    .bit_in (serIn),
    .value  (len_value),
    .full   (len_full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (start_c) state_next = PORT;
      PORT: if (port_full) state_next = LEN;
      LEN:  if (len_full) state_next = (len_now_c == '0) ? DONE : DATA;
      DATA: if (remaining == LEN_BITS'(1)) state_next = DONE;
      DONE: if (transmitted) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Payload counter plus Moore outputs registered from the next state, so they are glitch-free
  always_ff @(posedge clk) begin
    if (rst) begin
      remaining   <= '0;
      serOutValid <= 1'b0;
      portValid   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      if (len_full) begin
        remaining <= len_now_c;
      end else if (state == DATA) begin
        remaining <= remaining - LEN_BITS'(1);
      end
      serOutValid <= (state_next == DATA);
      portValid   <= (state_next == DATA) ? (NUM_PORTS'(1) << portSel) : '0;
      busy        <= (state_next != IDLE);
      done        <= (state_next == DONE);
    end
  end

endmodule
